// File: rtl/parity_frame_ctrl.sv
// Parallel-to-serial framer: DATA_W data bits (LSB first), then one parity bit.
// Even or odd parity is chosen per word and sampled when the word is accepted.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_in_valid/o_in_ready producer handshake (ready only in IDLE)
//   i_in_data, i_in_odd   word to frame and parity sense (1 = odd)
//   o_ser_valid/i_ser_ready consumer handshake for o_ser_bit
//   o_ser_bit, o_ser_last serial bit; last flags the parity beat
//   o_frame_done          1-cycle pulse after the parity beat is taken
//   o_frame_cnt           completed-frame count, wraps to 0
module parity_frame_ctrl #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic              i_in_odd,
   output logic              o_ser_valid,
   input  logic              i_ser_ready,
   output logic              o_ser_bit,
   output logic              o_ser_last,
   output logic              o_frame_done,
   output logic [CNT_W-1:0]  o_frame_cnt
);

   localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_shreg;
   logic              r_acc;
   logic              r_mode;
   logic [BC_W-1:0]   r_bit_cnt;
   logic              r_frame_done;
   logic [CNT_W-1:0]  r_frame_cnt;
   logic              w_accept;
   logic              w_shift;
   logic              w_par_take;

   // Every output except in_ready is a decode of registered state only.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_shift     = 1'b0;
      w_par_take  = 1'b0;
      o_in_ready  = 1'b0;
      o_ser_valid = 1'b0;
      o_ser_bit   = 1'b0;
      o_ser_last  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            o_in_ready = 1'b1;
            if (i_in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            o_ser_valid = 1'b1;
            o_ser_bit   = r_shreg[0];
            if (i_ser_ready) begin
               w_shift = 1'b1;
               if (r_bit_cnt == LAST_BIT) begin
                  w_state_nxt = S_PARITY;
               end
            end
         end
         S_PARITY: begin
            o_ser_valid = 1'b1;
            o_ser_last  = 1'b1;
            o_ser_bit   = r_acc ^ r_mode;
            if (i_ser_ready) begin
               w_par_take  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shreg      <= '0;
         r_acc        <= 1'b0;
         r_mode       <= 1'b0;
         r_bit_cnt    <= '0;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= '0;
      end else begin
         r_frame_done <= w_par_take;
         if (w_accept) begin
            r_shreg   <= i_in_data;
            r_mode    <= i_in_odd;
            r_acc     <= 1'b0;
            r_bit_cnt <= '0;
         end
         if (w_shift) begin
            r_acc     <= r_acc ^ r_shreg[0];
            r_shreg   <= r_shreg >> 1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         if (w_par_take) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   assign o_frame_done = r_frame_done;
   assign o_frame_cnt  = r_frame_cnt;

endmodule
